dm_timer: RTL and testbench

- Memory-mapped timer peripheral on the single-cycle CPU's data-memory bus.
- Acts as a responder beside dmem and uses the same cs / DM_R / DM_W_W / DM_W_H / DM_W_B strobe protocol that the CPU drives as initiator.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt.
- Top-level address decode asserts cs only for this block's window.

---
 rtl/dm_timer_pkg.sv | 68 ++++++
 rtl/dm_timer_prescaler.sv | 34 +++
 rtl/dm_timer.sv | 134 +++++++++++++
 tb/tb_dm_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_timer_pkg.sv
// Shared register map, CTRL bit positions and bus lane helpers for dm_timer.
package dm_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_COUNT    = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_W          = 3;

    // Byte enables for one bus write; word beats halfword beats byte.
    function automatic logic [3:0] lane_bytes(
        input logic       w,
        input logic       h,
        input logic       b,
        input logic [1:0] addr
    );
        logic [3:0] be;
        be = 4'b0000;
        if (w) begin
            be = 4'b1111;
        end else if (h) begin
            be = addr[1] ? 4'b1100 : 4'b0011;
        end else if (b) begin
            be = 4'b0001 << addr;
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] data,
        input logic        w,
        input logic        h,
        input logic        b,
        input logic [1:0]  addr
    );
        logic [3:0]  be;
        logic [31:0] aligned;
        logic [31:0] mask;
        be = lane_bytes(w, h, b, addr);
        if (w) begin
            aligned = data;
        end else if (h) begin
            aligned = {2{data[15:0]}};
        end else begin
            aligned = {4{data[7:0]}};
        end
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_word & ~mask) | (aligned & mask);
    endfunction

    function automatic logic lane_hits_bit0(
        input logic       w,
        input logic       h,
        input logic       b,
        input logic [1:0] addr
    );
        logic [3:0] be;
        be = lane_bytes(w, h, b, addr);
        return be[0];
    endfunction

endpackage

// File: rtl/dm_timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every (prescale+1) enabled cycles.
module dm_timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pcnt_q;
    logic             at_limit;

    assign at_limit = (pcnt_q == prescale);
    assign tick     = en && at_limit;

    // A PRESCALE write restarts the period even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (clr) begin
            pcnt_q <= '0;
        end else if (en) begin
            if (at_limit) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/dm_timer.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky match flag and level irq.
module dm_timer
    import dm_timer_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int PRE_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              DM_R,
    input  logic              DM_W_W,
    input  logic              DM_W_H,
    input  logic              DM_W_B,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [31:0]       DM_data_in,
    output logic [31:0]       DM_data_out,
    output logic              irq
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       count_q;
    logic [31:0]       compare_q;
    logic              match_q;
    logic [PRE_W-1:0]  prescale_q;

    logic              in_window;
    logic [2:0]        reg_idx;
    logic [31:0]       reg_val;
    logic [31:0]       wr_word;
    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_count;
    logic              wr_compare;
    logic              wr_status;
    logic              wr_prescale;
    logic              status_clr;
    logic              tick;
    logic              at_compare;
    logic              hw_match;

    assign in_window = (DM_addr[ADDR_W-1:5] == '0);
    assign reg_idx   = DM_addr[4:2];

    always_comb begin
        reg_val = 32'h0;
        if (in_window) begin
            case (reg_idx)
                REG_CTRL:     reg_val = 32'(ctrl_q);
                REG_COUNT:    reg_val = count_q;
                REG_COMPARE:  reg_val = compare_q;
                REG_STATUS:   reg_val = {31'h0, match_q};
                REG_PRESCALE: reg_val = 32'(prescale_q);
                default:      reg_val = 32'h0;
            endcase
        end
    end

    assign DM_data_out = (cs && DM_R) ? reg_val : 32'h0;

    // Sub-word writes merge into the currently addressed register's value.
    assign wr_word = lane_merge(reg_val, DM_data_in, DM_W_W, DM_W_H, DM_W_B, DM_addr[1:0]);

    assign wr_en       = cs && in_window && (DM_W_W || DM_W_H || DM_W_B);
    assign wr_ctrl     = wr_en && (reg_idx == REG_CTRL);
    assign wr_count    = wr_en && (reg_idx == REG_COUNT);
    assign wr_compare  = wr_en && (reg_idx == REG_COMPARE);
    assign wr_status   = wr_en && (reg_idx == REG_STATUS);
    assign wr_prescale = wr_en && (reg_idx == REG_PRESCALE);

    assign status_clr = wr_status && DM_data_in[0]
                        && lane_hits_bit0(DM_W_W, DM_W_H, DM_W_B, DM_addr[1:0]);

    dm_timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl_q[CTRL_EN]),
        .clr      (wr_prescale),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign at_compare = (count_q == compare_q);
    // A software COUNT write pre-empts both the increment and the compare.
    assign hw_match   = tick && !wr_count && at_compare;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            prescale_q <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= wr_word[CTRL_W-1:0];
            end
            if (wr_compare) begin
                compare_q <= wr_word;
            end
            if (wr_prescale) begin
                prescale_q <= wr_word[PRE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'h0;
        end else if (wr_count) begin
            count_q <= wr_word;
        end else if (tick) begin
            if (at_compare && ctrl_q[CTRL_AUTORELOAD]) begin
                count_q <= 32'h0;
            end else begin
                count_q <= count_q + 32'h1;
            end
        end
    end

    // Hardware set outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
        end else if (hw_match) begin
            match_q <= 1'b1;
        end else if (status_clr) begin
            match_q <= 1'b0;
        end
    end

    assign irq = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_dm_timer.sv
// Directed self-checking bench for dm_timer with an expected-value queue.
module tb_dm_timer;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;
    logic          cs;
    logic          DM_R;
    logic          DM_W_W;
    logic          DM_W_H;
    logic          DM_W_B;
    logic [AW-1:0] DM_addr;
    logic [31:0]   DM_data_in;
    logic [31:0]   DM_data_out;
    logic          irq;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];

    dm_timer #(
        .ADDR_W (AW),
        .PRE_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .DM_R        (DM_R),
        .DM_W_W      (DM_W_W),
        .DM_W_H      (DM_W_H),
        .DM_W_B      (DM_W_B),
        .DM_addr     (DM_addr),
        .DM_data_in  (DM_data_in),
        .DM_data_out (DM_data_out),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic w, input logic h, input logic b);
        cs         = 1'b1;
        DM_addr    = a;
        DM_data_in = d;
        DM_W_W     = w;
        DM_W_H     = h;
        DM_W_B     = b;
        @(posedge clk);
        #1;
        cs     = 1'b0;
        DM_W_W = 1'b0;
        DM_W_H = 1'b0;
        DM_W_B = 1'b0;
    endtask

    task automatic wr_word(input logic [AW-1:0] a, input logic [31:0] d);
        bus_write(a, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic compare(input string tag, input logic [31:0] got);
        logic [31:0] want;
        want = exp_q.pop_front();
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        cs      = 1'b1;
        DM_R    = 1'b1;
        DM_addr = a;
        #1;
        compare(tag, DM_data_out);
        cs   = 1'b0;
        DM_R = 1'b0;
    endtask

    task automatic irq_chk(input string tag, input logic e);
        exp_q.push_back({31'h0, e});
        #1;
        compare(tag, {31'h0, irq});
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        cs         = 1'b0;
        DM_R       = 1'b0;
        DM_W_W     = 1'b0;
        DM_W_H     = 1'b0;
        DM_W_B     = 1'b0;
        DM_addr    = '0;
        DM_data_in = '0;
        #25 rst_n  = 1'b1;
        step(1);

        // reset values
        read_chk("rst_ctrl", 11'h00, 32'h0);
        read_chk("rst_count", 11'h04, 32'h0);
        read_chk("rst_compare", 11'h08, 32'hFFFF_FFFF);
        read_chk("rst_status", 11'h0C, 32'h0);
        read_chk("rst_prescale", 11'h10, 32'h0);
        read_chk("rst_hole_18", 11'h18, 32'h0);
        irq_chk("rst_irq", 1'b0);
        step(1);
        exp_q.push_back(32'h0);
        cs = 1'b0; DM_R = 1'b1; DM_addr = 11'h08;
        #1;
        compare("no_cs_read", DM_data_out);
        DM_R = 1'b0;

        // autoreload count to 5 with irq
        wr_word(11'h08, 32'd5);
        wr_word(11'h00, 32'h7);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            read_chk("ar_count", 11'h04, 32'(i));
        end
        irq_chk("ar_irq_before", 1'b0);
        step(1);
        read_chk("ar_status", 11'h0C, 32'h1);
        irq_chk("ar_irq", 1'b1);
        read_chk("ar_reload", 11'h04, 32'h0);
        wr_word(11'h00, 32'h0);
        read_chk("dis_tick_taken", 11'h04, 32'h1);
        wr_word(11'h0C, 32'h1);
        read_chk("w1c_status", 11'h0C, 32'h0);
        irq_chk("w1c_irq", 1'b0);

        // prescale 3
        wr_word(11'h04, 32'h0);
        wr_word(11'h08, 32'hFFFF_FFFF);
        wr_word(11'h10, 32'd3);
        wr_word(11'h00, 32'h1);
        step(39);
        read_chk("pre_39", 11'h04, 32'd9);
        step(1);
        read_chk("pre_40", 11'h04, 32'd10);
        wr_word(11'h00, 32'h0);
        wr_word(11'h10, 32'hFFFF_1234);
        read_chk("prescale_width", 11'h10, 32'h0000_1234);
        wr_word(11'h10, 32'h0);
        read_chk("pre_held", 11'h04, 32'd10);

        // sub-word writes and decode
        wr_word(11'h04, 32'h1122_3344);
        bus_write(11'h06, 32'h0000_00AB, 1'b0, 1'b0, 1'b1);
        read_chk("byte_lane2", 11'h07, 32'h11AB_3344);
        bus_write(11'h05, 32'h0000_5566, 1'b0, 1'b1, 1'b0);
        read_chk("half_lane0", 11'h04, 32'h11AB_5566);
        bus_write(11'h0A, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
        read_chk("half_lane1", 11'h08, 32'hBEEF_FFFF);
        bus_write(11'h09, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
        read_chk("strobe_prio", 11'h08, 32'h1234_5678);
        wr_word(11'h18, 32'hDEAD_BEEF);
        wr_word(11'h28, 32'hDEAD_BEEF);
        read_chk("oow_ignored", 11'h08, 32'h1234_5678);
        read_chk("oow_read", 11'h24, 32'h0);
        wr_word(11'h00, 32'hFFFF_FFF8);
        read_chk("ctrl_mask", 11'h00, 32'h0);

        // wrap and match at zero
        wr_word(11'h04, 32'hFFFF_FFFF);
        wr_word(11'h08, 32'h0);
        wr_word(11'h00, 32'h1);
        step(1);
        read_chk("wrap_count", 11'h04, 32'h0);
        read_chk("wrap_status", 11'h0C, 32'h0);
        step(1);
        read_chk("zero_match_count", 11'h04, 32'h1);
        read_chk("zero_match_status", 11'h0C, 32'h1);
        irq_chk("irq_gated", 1'b0);
        wr_word(11'h04, 32'd100);
        read_chk("sw_count_wins", 11'h04, 32'd100);
        step(1);
        read_chk("after_sw_count", 11'h04, 32'd101);
        bus_write(11'h0D, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        read_chk("w1c_wrong_lane", 11'h0C, 32'h1);

        // W1C in the cycle of a new match
        wr_word(11'h00, 32'h0);
        wr_word(11'h04, 32'd10);
        wr_word(11'h08, 32'd12);
        wr_word(11'h00, 32'h5);
        step(2);
        wr_word(11'h0C, 32'h1);
        read_chk("set_wins", 11'h0C, 32'h1);
        irq_chk("set_wins_irq", 1'b1);
        read_chk("set_wins_count", 11'h04, 32'd13);
        wr_word(11'h00, 32'h4);
        wr_word(11'h0C, 32'h1);
        read_chk("late_w1c", 11'h0C, 32'h0);
        irq_chk("late_w1c_irq", 1'b0);

        // async reset mid-count
        wr_word(11'h04, 32'd20);
        wr_word(11'h08, 32'd20);
        wr_word(11'h00, 32'h5);
        step(1);
        irq_chk("pre_reset_irq", 1'b1);
        read_chk("pre_reset_count", 11'h04, 32'd21);
        rst_n = 1'b0;
        irq_chk("async_irq", 1'b0);
        read_chk("async_count", 11'h04, 32'h0);
        read_chk("async_compare", 11'h08, 32'hFFFF_FFFF);
        #2 rst_n = 1'b1;
        step(2);
        read_chk("post_reset_count", 11'h04, 32'h0);
        read_chk("post_reset_ctrl", 11'h00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
